// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the instruction fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP_INSTN = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    // Counters must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - small synchronous FIFO with flush, occupancy count and registered head
module if_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage is not reset; consumers qualify head with count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC, credit-limited imem requests, prefetch queue, redirect flush
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic [DATA_W-1:0] instn,
    output logic [ADDR_W-1:0] instn_pc,
    output logic              instn_valid,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CW = cnt_width(DEPTH);
    localparam int QW = DATA_W + ADDR_W;

    logic              running;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW:0]       in_use;
    logic [ADDR_W-1:0] pend_addr;
    logic [QW-1:0]     q_head;
    logic              req_fire;
    logic              rsp_keep;
    logic              deq;

    // Queued words plus in-flight requests never exceed DEPTH, so a response always fits.
    assign in_use         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = running && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep    = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign instn_valid = (count != '0);
    assign deq         = instn_valid && id_ready && !redirect_valid;
    assign instn       = instn_valid ? q_head[QW-1:ADDR_W] : DATA_W'(NOP_INSTN);
    assign instn_pc    = instn_valid ? q_head[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            pc      <= RESET_PC;
            drop    <= '0;
        end else begin
            running <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight is stale, including words already marked to drop.
                pc   <= redirect_pc;
                drop <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + ADDR_W'(PC_STEP);
                if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    // Addresses of issued requests; every response retires one, stale or not.
    if_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) pend_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .count     (outstanding),
        .head      (pend_addr)
    );

    if_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) pref_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, pend_addr}),
        .pop       (deq),
        .flush     (redirect_valid),
        .count     (count),
        .head      (q_head)
    );

endmodule
